reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 rdy  in  1  global enable; low freezes all state.
REQ-004 clr  in  1  ROB misprediction flush.
REQ-005 dsp_sgn  in  1  dispatch valid from decoder.
REQ-006 dsp_opcode  in  6  internal opcode.
REQ-007 dsp_Vj / dsp_Vk  in  32 each  operand values, meaningful when the matching ready bit is 1.
REQ-008 dsp_Qj / dsp_Qk  in  4 each  producing ROB tag, meaningful when the matching ready bit is 0.
REQ-009 dsp_Vj_rdy / dsp_Vk_rdy  in  1 each  operand already resolved.
REQ-010 dsp_imm / dsp_pc  in  32 each  immediate and instruction PC.
REQ-011 dsp_ROB_entry  in  4  destination ROB tag.
REQ-012 RS_full  out  1  no free entry; combinational from current state.
REQ-013 CDB_sgn / CDB_ROB_name / CDB_result  in  1/4/32  result broadcast.
REQ-014 ALU_sgn  out  1  issue valid to ALU, registered.
REQ-015 ALU_opcode  out  6  registered opcode.
REQ-016 ALU_lhs / ALU_rhs / ALU_imm / ALU_pc  out  32 each  registered operands.
REQ-017 ALU_ROB_entry  out  4  registered destination tag.

Function
REQ-018 8 entries; per entry: busy, opcode, Vj, Qj, Vj_rdy, Vk, Qk, Vk_rdy, imm, pc, ROB tag.
REQ-019 Dispatch: on an edge with dsp_sgn=1 and RS_full=0, the lowest-index non-busy entry (pre-edge state) is written and set busy.
REQ-020 A dispatch while RS_full=1 is dropped; upstream never asserts dsp_sgn while full.
REQ-021 Wakeup: on an edge with CDB_sgn=1, every busy entry whose operand is not ready and whose Q equals CDB_ROB_name captures CDB_result into V and sets that ready bit; j and k are handled independently, and both may wake on the same edge.
REQ-022 Select: each cycle, the lowest-index busy entry with both ready bits set is chosen. On the edge, its fields are registered to the ALU_* outputs, ALU_sgn is set to 1, and the entry is cleared. At most one issue per edge.
REQ-023 If no entry is ready, ALU_sgn is registered as 0. Every output is held exactly one cycle per issue; there is no backpressure.
REQ-024 Latency: an entry dispatched with both operands ready at edge t gives ALU_sgn=1 after edge t+1. An operand woken at edge t allows issue at edge t+1.
REQ-025 A slot freed by issue at edge t is reusable by a dispatch only from edge t+1 onward.
REQ-026 Same-edge dispatch and issue are both performed, on different entries.
REQ-027 clr=1: on the edge, all busy bits are cleared and ALU_sgn becomes 0. clr has priority over dispatch, wakeup and issue.
REQ-028 rdy=0: all entries and outputs hold; clr and CDB are ignored.

Reset
REQ-029 While rst=1, all busy bits are 0, ALU_sgn=0, all other ALU_* outputs are 0, and RS_full=0.
REQ-030 Assertion mid-operation discards all entries immediately; operation resumes on the first edge after deassertion.

Configuration
REQ-031 With RS_CDB_BYPASS_EN defined: when a dispatched operand is not ready and its Q equals CDB_ROB_name with CDB_sgn=1 in the same cycle, the entry is written with V=CDB_result and the ready bit set.
REQ-032 With RS_CDB_BYPASS_EN undefined: dispatched operands are stored as presented, and upstream performs the same-cycle CDB forwarding.

Verification
REQ-033 After reset, dispatch ADD with Vj=5, Vk=7, both ready -> one cycle later ALU_sgn=1, lhs=5, rhs=7, and ALU_ROB_entry equals the dispatched tag.
REQ-034 Dispatch an entry with Qj=3 not ready; 2 cycles later CDB_sgn=1, tag 3, result 0x10 -> issue on the following edge with ALU_lhs=0x10.
REQ-035 Dispatch 8 entries with non-ready operands -> RS_full=1; a 9th dispatch is dropped; one CDB wakeup, then issue -> RS_full=0 one cycle after the issue.
REQ-036 Entries 0 and 2 are both ready -> entry 0 issues first, entry 2 on the next edge.
REQ-037 6 busy entries, then clr=1 together with dsp_sgn=1 -> all entries empty and ALU_sgn=0 on the next cycle.
REQ-038 With RS_CDB_BYPASS_EN defined: dispatch Qk=9 while CDB tag 9 carries 0xAB -> issue the next cycle with ALU_rhs=0xAB. With it undefined, the entry does not issue.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station: 8-entry issue buffer between the decoder and a single ALU.
// Entries are dispatched into the lowest free slot and woken by CDB broadcasts.
// Each cycle, the lowest-index entry with both operands resolved is issued to
// registered ALU outputs.
//
// Ports:
//   clk_i, rst_i (async, active-high), rdy_i (global enable), clr_i (flush)
//   dsp_*_i       dispatch request from the decoder
//   rs_full_o     no free entry (combinational from current state)
//   cdb_*_i       result broadcast bus
//   alu_*_o       registered issue to the ALU, valid for one cycle when alu_sgn_o=1
//
// Optional feature: define RS_CDB_BYPASS_EN to capture a same-cycle CDB result
// into a dispatched operand that is not yet ready.
module reservation_station (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rdy_i,
    input  logic        clr_i,
    input  logic        dsp_sgn_i,
    input  logic [5:0]  dsp_opcode_i,
    input  logic [31:0] dsp_vj_i,
    input  logic [31:0] dsp_vk_i,
    input  logic [3:0]  dsp_qj_i,
    input  logic [3:0]  dsp_qk_i,
    input  logic        dsp_vj_rdy_i,
    input  logic        dsp_vk_rdy_i,
    input  logic [31:0] dsp_imm_i,
    input  logic [31:0] dsp_pc_i,
    input  logic [3:0]  dsp_rob_entry_i,
    output logic        rs_full_o,
    input  logic        cdb_sgn_i,
    input  logic [3:0]  cdb_rob_name_i,
    input  logic [31:0] cdb_result_i,
    output logic        alu_sgn_o,
    output logic [5:0]  alu_opcode_o,
    output logic [31:0] alu_lhs_o,
    output logic [31:0] alu_rhs_o,
    output logic [31:0] alu_imm_o,
    output logic [31:0] alu_pc_o,
    output logic [3:0]  alu_rob_entry_o
);
    localparam int unsigned Entries = 8;

    logic [Entries-1:0] busy_q, busy_d, vj_rdy_q, vj_rdy_d, vk_rdy_q, vk_rdy_d;
    logic [5:0]         op_q  [Entries];
    logic [5:0]         op_d  [Entries];
    logic [31:0]        vj_q  [Entries];
    logic [31:0]        vj_d  [Entries];
    logic [31:0]        vk_q  [Entries];
    logic [31:0]        vk_d  [Entries];
    logic [3:0]         qj_q  [Entries];
    logic [3:0]         qj_d  [Entries];
    logic [3:0]         qk_q  [Entries];
    logic [3:0]         qk_d  [Entries];
    logic [31:0]        imm_q [Entries];
    logic [31:0]        imm_d [Entries];
    logic [31:0]        pc_q  [Entries];
    logic [31:0]        pc_d  [Entries];
    logic [3:0]         rob_q [Entries];
    logic [3:0]         rob_d [Entries];

    logic        alu_sgn_q, alu_sgn_d;
    logic [5:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;
    logic [31:0] alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [3:0]  alu_rob_q, alu_rob_d;

    logic [2:0]  free_idx, sel_idx;
    logic        sel_vld;
    logic [31:0] new_vj, new_vk;
    logic        new_vj_rdy, new_vk_rdy;

    assign rs_full_o = &busy_q;

    // Lowest-index free slot and lowest-index ready entry (descending loop, last hit wins).
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel_vld  = 1'b0;
        for (int i = Entries - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = 3'(i);
            if (busy_q[i] && vj_rdy_q[i] && vk_rdy_q[i]) begin
                sel_idx = 3'(i);
                sel_vld = 1'b1;
            end
        end
    end

    // Dispatched operand values, optionally forwarded from the same-cycle CDB.
    always_comb begin
        new_vj     = dsp_vj_i;
        new_vk     = dsp_vk_i;
        new_vj_rdy = dsp_vj_rdy_i;
        new_vk_rdy = dsp_vk_rdy_i;
`ifdef RS_CDB_BYPASS_EN
        if (cdb_sgn_i && !dsp_vj_rdy_i && dsp_qj_i == cdb_rob_name_i) begin
            new_vj     = cdb_result_i;
            new_vj_rdy = 1'b1;
        end
        if (cdb_sgn_i && !dsp_vk_rdy_i && dsp_qk_i == cdb_rob_name_i) begin
            new_vk     = cdb_result_i;
            new_vk_rdy = 1'b1;
        end
`endif
    end

    always_comb begin
        busy_d   = busy_q;
        vj_rdy_d = vj_rdy_q;
        vk_rdy_d = vk_rdy_q;
        op_d     = op_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        rob_d    = rob_q;
        alu_sgn_d = 1'b0;
        alu_op_d  = alu_op_q;
        alu_lhs_d = alu_lhs_q;
        alu_rhs_d = alu_rhs_q;
        alu_imm_d = alu_imm_q;
        alu_pc_d  = alu_pc_q;
        alu_rob_d = alu_rob_q;

        if (cdb_sgn_i) begin
            for (int i = 0; i < Entries; i++) begin
                if (busy_q[i] && !vj_rdy_q[i] && qj_q[i] == cdb_rob_name_i) begin
                    vj_d[i]     = cdb_result_i;
                    vj_rdy_d[i] = 1'b1;
                end
                if (busy_q[i] && !vk_rdy_q[i] && qk_q[i] == cdb_rob_name_i) begin
                    vk_d[i]     = cdb_result_i;
                    vk_rdy_d[i] = 1'b1;
                end
            end
        end

        if (sel_vld) begin
            alu_sgn_d       = 1'b1;
            alu_op_d        = op_q[sel_idx];
            alu_lhs_d       = vj_q[sel_idx];
            alu_rhs_d       = vk_q[sel_idx];
            alu_imm_d       = imm_q[sel_idx];
            alu_pc_d        = pc_q[sel_idx];
            alu_rob_d       = rob_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
        end

        // free_idx is a non-busy slot, so it never collides with the issuing entry.
        if (dsp_sgn_i && !rs_full_o) begin
            busy_d[free_idx]   = 1'b1;
            op_d[free_idx]     = dsp_opcode_i;
            vj_d[free_idx]     = new_vj;
            vk_d[free_idx]     = new_vk;
            vj_rdy_d[free_idx] = new_vj_rdy;
            vk_rdy_d[free_idx] = new_vk_rdy;
            qj_d[free_idx]     = dsp_qj_i;
            qk_d[free_idx]     = dsp_qk_i;
            imm_d[free_idx]    = dsp_imm_i;
            pc_d[free_idx]     = dsp_pc_i;
            rob_d[free_idx]    = dsp_rob_entry_i;
        end

        if (clr_i) begin
            busy_d    = '0;
            alu_sgn_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            vj_rdy_q  <= '0;
            vk_rdy_q  <= '0;
            for (int i = 0; i < Entries; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            alu_sgn_q <= 1'b0;
            alu_op_q  <= '0;
            alu_lhs_q <= '0;
            alu_rhs_q <= '0;
            alu_imm_q <= '0;
            alu_pc_q  <= '0;
            alu_rob_q <= '0;
        end else if (rdy_i) begin
            busy_q    <= busy_d;
            vj_rdy_q  <= vj_rdy_d;
            vk_rdy_q  <= vk_rdy_d;
            op_q      <= op_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            rob_q     <= rob_d;
            alu_sgn_q <= alu_sgn_d;
            alu_op_q  <= alu_op_d;
            alu_lhs_q <= alu_lhs_d;
            alu_rhs_q <= alu_rhs_d;
            alu_imm_q <= alu_imm_d;
            alu_pc_q  <= alu_pc_d;
            alu_rob_q <= alu_rob_d;
        end
    end

    assign alu_sgn_o       = alu_sgn_q;
    assign alu_opcode_o    = alu_op_q;
    assign alu_lhs_o       = alu_lhs_q;
    assign alu_rhs_o       = alu_rhs_q;
    assign alu_imm_o       = alu_imm_q;
    assign alu_pc_o        = alu_pc_q;
    assign alu_rob_entry_o = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;
    logic        clk_i = 1'b0;
    logic        rst_i, rdy_i, clr_i, dsp_sgn_i, dsp_vj_rdy_i, dsp_vk_rdy_i, cdb_sgn_i;
    logic [5:0]  dsp_opcode_i;
    logic [31:0] dsp_vj_i, dsp_vk_i, dsp_imm_i, dsp_pc_i, cdb_result_i;
    logic [3:0]  dsp_qj_i, dsp_qk_i, dsp_rob_entry_i, cdb_rob_name_i;
    logic        rs_full_o, alu_sgn_o;
    logic [5:0]  alu_opcode_o;
    logic [31:0] alu_lhs_o, alu_rhs_o, alu_imm_o, alu_pc_o;
    logic [3:0]  alu_rob_entry_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    reservation_station dut (
        .clk_i(clk_i), .rst_i(rst_i), .rdy_i(rdy_i), .clr_i(clr_i),
        .dsp_sgn_i(dsp_sgn_i), .dsp_opcode_i(dsp_opcode_i),
        .dsp_vj_i(dsp_vj_i), .dsp_vk_i(dsp_vk_i), .dsp_qj_i(dsp_qj_i), .dsp_qk_i(dsp_qk_i),
        .dsp_vj_rdy_i(dsp_vj_rdy_i), .dsp_vk_rdy_i(dsp_vk_rdy_i),
        .dsp_imm_i(dsp_imm_i), .dsp_pc_i(dsp_pc_i), .dsp_rob_entry_i(dsp_rob_entry_i),
        .rs_full_o(rs_full_o),
        .cdb_sgn_i(cdb_sgn_i), .cdb_rob_name_i(cdb_rob_name_i), .cdb_result_i(cdb_result_i),
        .alu_sgn_o(alu_sgn_o), .alu_opcode_o(alu_opcode_o),
        .alu_lhs_o(alu_lhs_o), .alu_rhs_o(alu_rhs_o), .alu_imm_o(alu_imm_o),
        .alu_pc_o(alu_pc_o), .alu_rob_entry_o(alu_rob_entry_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dsp(input logic [5:0] op, input logic [31:0] vj, input logic vjr,
                       input logic [3:0] qj, input logic [31:0] vk, input logic vkr,
                       input logic [3:0] qk, input logic [3:0] rob);
        dsp_sgn_i = 1'b1; dsp_opcode_i = op;
        dsp_vj_i = vj; dsp_vj_rdy_i = vjr; dsp_qj_i = qj;
        dsp_vk_i = vk; dsp_vk_rdy_i = vkr; dsp_qk_i = qk;
        dsp_rob_entry_i = rob;
    endtask

    task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] res);
        cdb_sgn_i = v; cdb_rob_name_i = tag; cdb_result_i = res;
    endtask

    initial begin
        rst_i = 1'b1; rdy_i = 1'b1; clr_i = 1'b0; dsp_sgn_i = 1'b0;
        dsp_opcode_i = '0; dsp_vj_i = '0; dsp_vk_i = '0; dsp_qj_i = '0; dsp_qk_i = '0;
        dsp_vj_rdy_i = 1'b0; dsp_vk_rdy_i = 1'b0; dsp_imm_i = '0; dsp_pc_i = '0;
        dsp_rob_entry_i = '0;
        cdb(1'b0, 4'd0, 32'd0);
        #1;
        chk("reset_alu_sgn", alu_sgn_o, 0);
        chk("reset_rs_full", rs_full_o, 0);
        chk("reset_alu_lhs", alu_lhs_o, 0);
        chk("reset_alu_rob", alu_rob_entry_o, 0);
        step(); step();
        rst_i = 1'b0;
        step();

        // Both operands ready: issue one edge after dispatch.
        dsp(6'd1, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd4);
        dsp_imm_i = 32'h20; dsp_pc_i = 32'h1000;
        step();
        dsp_sgn_i = 1'b0;
        chk("add_not_yet", alu_sgn_o, 0);
        step();
        chk("add_sgn", alu_sgn_o, 1);
        chk("add_lhs", alu_lhs_o, 5);
        chk("add_rhs", alu_rhs_o, 7);
        chk("add_rob", alu_rob_entry_o, 4);
        chk("add_op", alu_opcode_o, 1);
        chk("add_imm", alu_imm_o, 32'h20);
        chk("add_pc", alu_pc_o, 32'h1000);
        step();
        chk("add_one_cycle", alu_sgn_o, 0);

        // Qj=3 pending, woken two cycles later.
        dsp(6'd2, 32'hDEAD, 1'b0, 4'd3, 32'd2, 1'b1, 4'd0, 4'd5);
        step();
        dsp_sgn_i = 1'b0;
        step();
        chk("wait_no_issue", alu_sgn_o, 0);
        cdb(1'b1, 4'd3, 32'h10);
        step();
        cdb(1'b0, 4'd0, 32'd0);
        chk("wake_edge_no_issue", alu_sgn_o, 0);
        step();
        chk("wake_sgn", alu_sgn_o, 1);
        chk("wake_lhs", alu_lhs_o, 32'h10);
        chk("wake_rhs", alu_rhs_o, 2);
        chk("wake_rob", alu_rob_entry_o, 5);
        step();

        // Fill all 8 entries, entry i waits on tag i+1.
        for (int i = 0; i < 8; i++) begin
            chk("fill_not_full", rs_full_o, 0);
            dsp(6'd3, 32'd0, 1'b0, 4'(i + 1), 32'd9, 1'b1, 4'd0, 4'(i));
            step();
        end
        chk("full", rs_full_o, 1);
        // Dropped dispatch: if written it would issue at the next edge.
        dsp(6'd4, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd15);
        step();
        dsp_sgn_i = 1'b0;
        chk("drop_full", rs_full_o, 1);
        cdb(1'b1, 4'd6, 32'h55);
        step();
        cdb(1'b0, 4'd0, 32'd0);
        chk("drop_no_issue", alu_sgn_o, 0);
        chk("wake_still_full", rs_full_o, 1);
        step();
        chk("full_issue_sgn", alu_sgn_o, 1);
        chk("full_issue_rob", alu_rob_entry_o, 5);
        chk("full_issue_lhs", alu_lhs_o, 32'h55);
        chk("full_after_issue", rs_full_o, 0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("clr_empty", rs_full_o, 0);

        // Entries 0 and 2 wake on the same tag; entry 1 stays blocked.
        dsp(6'd5, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd10, 4'd0);
        step();
        dsp(6'd6, 32'd0, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 4'd1);
        step();
        dsp(6'd7, 32'd0, 1'b0, 4'd10, 32'd3, 1'b1, 4'd0, 4'd2);
        step();
        dsp_sgn_i = 1'b0;
        cdb(1'b1, 4'd10, 32'hA0);
        step();
        cdb(1'b0, 4'd0, 32'd0);
        step();
        chk("prio_first_rob", alu_rob_entry_o, 0);
        chk("prio_first_rhs", alu_rhs_o, 32'hA0);
        step();
        chk("prio_second_sgn", alu_sgn_o, 1);
        chk("prio_second_rob", alu_rob_entry_o, 2);
        chk("prio_second_lhs", alu_lhs_o, 32'hA0);
        step();
        chk("prio_done", alu_sgn_o, 0);

        // Six busy entries, then flush with a simultaneous dispatch.
        for (int i = 0; i < 5; i++) begin
            dsp(6'd8, 32'd0, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 4'(8 + i));
            step();
        end
        chk("six_not_full", rs_full_o, 0);
        dsp(6'd9, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd14);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        dsp_sgn_i = 1'b0;
        chk("flush_sgn", alu_sgn_o, 0);
        cdb(1'b1, 4'd13, 32'h1);
        step();
        chk("flush_dsp_dropped", alu_sgn_o, 0);
        cdb(1'b1, 4'd11, 32'h1);
        step();
        cdb(1'b0, 4'd0, 32'd0);
        step();
        chk("flush_entries_gone", alu_sgn_o, 0);

        // Same-cycle CDB during dispatch of Qk=9.
        dsp(6'd10, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 4'd7);
        cdb(1'b1, 4'd9, 32'hAB);
        step();
        dsp_sgn_i = 1'b0;
        cdb(1'b0, 4'd0, 32'd0);
        step();
`ifdef RS_CDB_BYPASS_EN
        chk("bypass_sgn", alu_sgn_o, 1);
        chk("bypass_rhs", alu_rhs_o, 32'hAB);
`else
        chk("nobypass_sgn", alu_sgn_o, 0);
`endif
        step();

        // rdy=0 freezes state: a dispatch is not taken.
        rdy_i = 1'b0;
        dsp(6'd11, 32'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd3);
        step();
        dsp_sgn_i = 1'b0;
        rdy_i = 1'b1;
        step();
        chk("rdy_low_hold", alu_sgn_o, 0);

        // Mid-operation reset discards a ready entry before it issues.
        dsp(6'd12, 32'd4, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd6);
        step();
        dsp_sgn_i = 1'b0;
        rst_i = 1'b1;
        #2;
        chk("midrst_full", rs_full_o, 0);
        rst_i = 1'b0;
        step();
        chk("midrst_discard", alu_sgn_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
